// File: rtl/alu_seq.sv
// Sequential N-bit ALU with valid/ready handshakes, registered result and
// N/Z/C/V flags. Shifts run one bit per cycle for B[SW-1:0] cycles.
module alu_seq #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [3:0]   ALUControl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Y,
   output logic [3:0]   flags
);

   localparam int unsigned SW = $clog2(N);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpNot = 4'b0010;
   localparam logic [3:0] OpXor = 4'b0011;
   localparam logic [3:0] OpSub = 4'b0101;
   localparam logic [3:0] OpLsl = 4'b0110;
   localparam logic [3:0] OpLsr = 4'b0111;
   localparam logic [3:0] OpAsl = 4'b1000;
   localparam logic [3:0] OpAsr = 4'b1001;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
   typedef enum logic [1:0] {ShLeft, ShRightLog, ShRightArith} shmode_e;

   state_e          state_q, state_d;
   shmode_e         mode_q, mode_d;
   logic [N-1:0]    acc_q;
   logic [SW-1:0]   cnt_q;
   logic [N-1:0]    y_q;
   logic [3:0]      flags_q;

   logic [N:0]      add_ext, sub_ext;
   logic [N-1:0]    alu_y;
   logic            alu_c, alu_v;
   logic            is_shift;
   logic [SW-1:0]   shamt;
   logic [N-1:0]    sh_next;
   logic            sh_out;
   logic            accept;
   logic            start_shift;
   logic            last_shift;

   assign shamt       = B[SW-1:0];
   assign accept      = (state_q == StIdle) && in_valid;
   assign start_shift = accept && is_shift && (shamt != '0);
   assign last_shift  = (state_q == StShift) && (cnt_q == SW'(1));

   // Single-cycle result; shift opcodes here only cover the s=0 case (Y=A, C=0).
   always_comb begin
      add_ext  = {1'b0, A} + {1'b0, B};
      sub_ext  = {1'b0, A} - {1'b0, B};
      alu_y    = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      is_shift = 1'b0;
      mode_d   = ShRightLog;
      case (ALUControl)
         OpAnd: alu_y = A & B;
         OpOr:  alu_y = A | B;
         OpNot: alu_y = ~A;
         OpXor: alu_y = A ^ B;
         OpSub: begin
            alu_y = sub_ext[N-1:0];
            alu_c = ~sub_ext[N];  // carry means no borrow
            alu_v = (A[N-1] != B[N-1]) && (alu_y[N-1] != A[N-1]);
         end
         OpLsl, OpAsl: begin
            alu_y    = A;
            is_shift = 1'b1;
            mode_d   = ShLeft;
         end
         OpLsr: begin
            alu_y    = A;
            is_shift = 1'b1;
            mode_d   = ShRightLog;
         end
         OpAsr: begin
            alu_y    = A;
            is_shift = 1'b1;
            mode_d   = ShRightArith;
         end
         default: begin  // ADD and the unused 1010-1111 codes
            alu_y = add_ext[N-1:0];
            alu_c = add_ext[N];
            alu_v = (A[N-1] == B[N-1]) && (alu_y[N-1] != A[N-1]);
         end
      endcase
   end

   // One shift step of the accumulator and the bit that falls off.
   always_comb begin
      sh_next = acc_q;
      sh_out  = 1'b0;
      unique case (mode_q)
         ShLeft: begin
            sh_next = {acc_q[N-2:0], 1'b0};
            sh_out  = acc_q[N-1];
         end
         ShRightLog: begin
            sh_next = {1'b0, acc_q[N-1:1]};
            sh_out  = acc_q[0];
         end
         ShRightArith: begin
            sh_next = {acc_q[N-1], acc_q[N-1:1]};
            sh_out  = acc_q[0];
         end
         default: begin
            sh_next = acc_q;
            sh_out  = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = (is_shift && (shamt != '0)) ? StShift : StDone;
            end
         end
         StShift: begin
            if (cnt_q == SW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: handshake signals follow the state directly.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   // Datapath: shift accumulator, counter and result/flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= ShLeft;
         y_q     <= '0;
         flags_q <= '0;
      end else if (start_shift) begin
         acc_q  <= A;
         cnt_q  <= shamt;
         mode_q <= mode_d;
      end else if (accept) begin
         y_q     <= alu_y;
         flags_q <= {alu_y[N-1], (alu_y == '0), alu_c, alu_v};
      end else if (state_q == StShift) begin
         acc_q <= sh_next;
         cnt_q <= cnt_q - SW'(1);
         if (last_shift) begin
            y_q     <= sh_next;
            flags_q <= {sh_next[N-1], (sh_next == '0), sh_out, 1'b0};
         end
      end
   end

   assign Y     = y_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): hand-computed results, flags and latency.
module tb_alu_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] ALUControl;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] Y;
   logic [3:0] flags;

   int errors = 0;
   int checks = 0;

   alu_seq #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUControl(ALUControl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op with out_ready low, measure latency, check result, then consume it.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input int exp_lat,
                         input logic [7:0] exp_y, input logic [3:0] exp_f);
      int lat;
      @(negedge clk);
      A = a; B = b; ALUControl = op; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = ~a; B = ~b; ALUControl = 4'b0011;  // operands must already be captured
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " Y"}, Y, exp_y);
      check({tag, " flags"}, flags, exp_f);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " in_ready after consume"}, in_ready, 1'b1);
      check({tag, " out_valid after consume"}, out_valid, 1'b0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALUControl = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset Y", Y, 8'h00);
      check("reset flags", flags, 4'h0);
      check("reset out_valid", out_valid, 1'b0);
      check("reset in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // flags are {N,Z,C,V}
      run_op("add 7f+01", 8'h7F, 8'h01, 4'b0100, 1, 8'h80, 4'b1001);
      run_op("sub 05-05", 8'h05, 8'h05, 4'b0101, 1, 8'h00, 4'b0110);
      run_op("sub 03-05", 8'h03, 8'h05, 4'b0101, 1, 8'hFE, 4'b1000);
      run_op("sub 80-01", 8'h80, 8'h01, 4'b0101, 1, 8'h7F, 4'b0011);
      run_op("add ff+01", 8'hFF, 8'h01, 4'b0100, 1, 8'h00, 4'b0110);
      run_op("xor", 8'hA5, 8'h0F, 4'b0011, 1, 8'hAA, 4'b1000);
      run_op("or", 8'h41, 8'h02, 4'b0001, 1, 8'h43, 4'b0000);
      run_op("asr 90>>3", 8'h90, 8'h03, 4'b1001, 4, 8'hF2, 4'b1000);
      run_op("lsl 81<<1", 8'h81, 8'h01, 4'b0110, 2, 8'h02, 4'b0010);
      run_op("lsr 81>>1", 8'h81, 8'h01, 4'b0111, 2, 8'h40, 4'b0010);
      run_op("asl 03<<7", 8'h03, 8'h07, 4'b1000, 8, 8'h80, 4'b1010);
      run_op("lsr 01>>7", 8'h01, 8'h07, 4'b0111, 8, 8'h00, 4'b0100);

      // Backpressure: result held, new request ignored.
      @(negedge clk);
      A = 8'hF0; B = 8'h3C; ALUControl = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      A = 8'h11; B = 8'h22; ALUControl = 4'b0100;  // in_valid stays high
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", out_valid, 1'b1);
         check("bp in_ready", in_ready, 1'b0);
         check("bp Y", Y, 8'h30);
         check("bp flags", flags, 4'b0000);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp release in_ready", in_ready, 1'b1);
      check("bp release out_valid", out_valid, 1'b0);
      check("bp hold Y in idle", Y, 8'h30);

      // Reset during a 7-step shift.
      @(negedge clk);
      A = 8'hFF; B = 8'h07; ALUControl = 4'b0111; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst Y", Y, 8'h00);
      check("midrst flags", flags, 4'h0);
      check("midrst out_valid", out_valid, 1'b0);
      check("midrst in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("midrst no stale result", seen, 0);
      check("midrst Y after", Y, 8'h00);

      // Edge opcodes.
      run_op("op1111 add", 8'h10, 8'h20, 4'b1111, 1, 8'h30, 4'b0000);
      run_op("lsr s=0", 8'hA5, 8'h08, 4'b0111, 1, 8'hA5, 4'b1000);
      run_op("not ff", 8'hFF, 8'h00, 4'b0010, 1, 8'h00, 4'b0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential ALU: the next generation of the team's combinational N-bit ALU.
- Keeps the same 4-bit opcode map. Adds registered results, an N/Z/C/V flag register, and shifts by a variable amount taken from B, executed iteratively one bit per cycle.
- Uses valid/ready handshakes on both input and output, so it can sit between a register file/control unit and a writeback stage.

Parameters:
- N, 8, datapath width in bits; legal values are N >= 2.
- SW, $clog2(N), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation.
- A  in  N  operand A.
- B  in  N  operand B; B[SW-1:0] is the shift amount for shift opcodes.
- ALUControl  in  4  opcode.
- out_valid  out  1  Y/flags hold a fresh result.
- out_ready  in  1  consumer takes the result.
- Y  out  N  registered result.
- flags  out  4  {N,Z,C,V}, registered with Y.

Behaviour:
- Reset: asynchronous, active-high.
  - Y=0, flags=0, out_valid=0, state=IDLE, so in_ready=1.
  - Asserting rst mid-operation aborts the operation: no result is produced and any partial shift is discarded.
- Opcodes (encoding unchanged from the combinational ALU):
  - 0000 AND, 0001 OR, 0010 NOT A, 0011 XOR, 0100 ADD, 0101 SUB (A-B).
  - 0110 logical shift left, 0111 logical shift right.
  - 1000 arithmetic shift left (identical to logical left), 1001 arithmetic shift right (sign-fill).
  - 1010-1111 execute as ADD.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE).
  - IDLE with in_valid=1 (accept edge):
    - Non-shift opcode, or shift with s=B[SW-1:0]=0: compute result, load Y/flags, go to DONE.
    - Shift with s>0: acc<=A, cnt<=s, go to SHIFT.
  - SHIFT: each edge shifts acc one bit in the selected direction, records the bit shifted out, and decrements cnt.
    - On the edge where cnt==1: load Y=shifted value and flags, go to DONE.
  - DONE: Y/flags held stable. On an edge with out_ready=1, go to IDLE; otherwise stay.
- Latency from the accept edge to out_valid high:
  - 1 cycle for non-shift ops and s=0.
  - 1+s cycles for shifts with s>0.
- Throughput: at most one operation every 2 cycles. An operation cannot be accepted in the same cycle a result is consumed.
- Input handling:
  - in_valid while in_ready=0 is ignored; the block does not capture it.
  - A, B and ALUControl are sampled only on the accept edge and may change afterwards.
- Output hold: Y/flags keep the last result in IDLE and are overwritten only by the next completed operation.
- Arithmetic:
  - All operations are N-bit and wrap modulo 2^N.
  - ADD: C = carry out of bit N-1; V = (A[N-1]==B[N-1]) && (Y[N-1]!=A[N-1]).
  - SUB: C = 1 when no borrow (A>=B unsigned); V = (A[N-1]!=B[N-1]) && (Y[N-1]!=A[N-1]).
  - Shifts: C = last bit shifted out (0 if s=0); V=0.
  - Logic ops: C=0, V=0.
  - All ops: Z=(Y==0), N=Y[N-1].
- Shift amounts: s ranges 0..2^SW-1. For non-power-of-2 N, s>=N is legal and yields all-zero (logical) or all-sign (arithmetic right) results.

Test Plan (N=8):
1. ADD: A=8'h7F, B=8'h01, op 0100, out_ready=1 → one cycle later out_valid=1, Y=8'h80, flags N=1,Z=0,C=0,V=1. in_ready=1 on the following cycle.
2. SUB: A=8'h05, B=8'h05, op 0101 → Y=8'h00, flags N=0,Z=1,C=1,V=0. Then A=8'h03, B=8'h05 → Y=8'hFE, N=1, C=0.
3. Arithmetic shift right: A=8'h90, B=8'h03, op 1001 → out_valid 4 cycles after accept, Y=8'hF2, C=0. Logical left: A=8'h81, B=8'h01, op 0110 → Y=8'h02, C=1, latency 2.
4. Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 with new operands → Y/flags/out_valid unchanged, in_ready=0, no new op captured. out_ready=1 → IDLE next cycle.
5. Reset mid-shift: start shift with s=7, assert rst on cycle 3 → immediately Y=0, flags=0, out_valid=0, in_ready=1. No stale result after rst deasserts.
6. Edge opcodes: op 1111 with A=8'h10, B=8'h20 → Y=8'h30 (ADD). op 0111 with B[2:0]=0, A=8'hA5 → Y=8'hA5, C=0, latency 1. op 0010, A=8'hFF → Y=8'h00, Z=1.
